// File: rtl/hpu_if_ras_ctrl.sv
// hpu_if_ras_ctrl: speculative return-address stack for the HPU IF stage.
// A CALL pushes PC+4. A RET pops when the stack is non-empty. The top
// entry is the predicted target for a RET in IF1 in the same cycle.
// Each instruction receives a checkpoint (ptr, cnt, and optionally the top
// entry). A back-end flush uses that checkpoint to restore the stack.
// Optional feature macro: HPU_RAS_CKPT_TOP_EN. When it is defined, the top
// entry is included in the checkpoint and rewritten on flush.

package hpu_if_ras_pkg;

    typedef logic [31:0] pc_t;

    typedef enum logic [2:0] {
        IS_NORMAL = 3'd0,
        IS_BRANCH = 3'd1,
        IS_JAL    = 3'd2,
        IS_JALR   = 3'd3,
        IS_CALL   = 3'd4,
        IS_RET    = 3'd5
    } qdec_type_e;

endpackage : hpu_if_ras_pkg

module hpu_if_ras_ctrl
    import hpu_if_ras_pkg::*;
#(
    parameter  int RAS_DEPTH = 8,
    localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             qdec_vld_i,
    input  qdec_type_e       qdec_type_i,
    input  pc_t              cur_inst_pc_if1_i,
    output logic             ras_pred_vld_o,
    output pc_t              ras_pred_npc_o,
    output logic [PTR_W-1:0] ras_ckpt_ptr_o,
    output logic [PTR_W:0]   ras_ckpt_cnt_o,
    output pc_t              ras_ckpt_top_o,
    input  logic             flush_i,
    input  logic [PTR_W-1:0] flush_ckpt_ptr_i,
    input  logic [PTR_W:0]   flush_ckpt_cnt_i,
    input  pc_t              flush_ckpt_top_i
);

    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam pc_t              PC_INC   = 32'd4;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    pc_t              entry_q [RAS_DEPTH];
    pc_t              entry_d [RAS_DEPTH];

    logic             not_empty_s;
    logic [PTR_W-1:0] ptr_inc_s;
    logic [PTR_W-1:0] ptr_dec_s;
    pc_t              ret_addr_s;
    pc_t              top_s;

    assign not_empty_s = (cnt_q != CNT_ZERO);
    // ptr is exactly log2(depth) bits wide, so plain +/- wraps modulo the depth
    assign ptr_inc_s   = ptr_q + PTR_ONE;
    assign ptr_dec_s   = ptr_q - PTR_ONE;
    // carry out of bit 31 is dropped on purpose: a CALL at the top of memory returns to 0
    assign ret_addr_s  = cur_inst_pc_if1_i + PC_INC;
    assign top_s       = entry_q[ptr_q];

    // Prediction and checkpoint outputs are taken directly from the stored state
    assign ras_pred_vld_o = not_empty_s;
    assign ras_pred_npc_o = top_s;
    assign ras_ckpt_ptr_o = ptr_q;
    assign ras_ckpt_cnt_o = cnt_q;

`ifdef HPU_RAS_CKPT_TOP_EN
    assign ras_ckpt_top_o = top_s;
`else
    logic unused_flush_top_s;
    assign ras_ckpt_top_o     = 32'h0000_0000;
    assign unused_flush_top_s = ^flush_ckpt_top_i;
`endif

    // Next-state selection: flush restore first, then qdec push/pop, otherwise hold
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        if (flush_i) begin
            // any qdec event in this cycle is on the wrong path and is dropped
            ptr_d = flush_ckpt_ptr_i;
            cnt_d = flush_ckpt_cnt_i;
`ifdef HPU_RAS_CKPT_TOP_EN
            entry_d[flush_ckpt_ptr_i] = flush_ckpt_top_i;
`endif
        end else if (qdec_vld_i) begin
            case (qdec_type_i)
                IS_CALL: begin
                    // at full occupancy the push wraps onto the oldest entry
                    ptr_d            = ptr_inc_s;
                    entry_d[ptr_inc_s] = ret_addr_s;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = CNT_MAX;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                IS_RET: begin
                    // a RET on an empty stack leaves state alone; fetch falls back to BTB
                    if (not_empty_s) begin
                        ptr_d = ptr_dec_s;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        ptr_d = ptr_q;
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    ptr_d = ptr_q;
                    cnt_d = cnt_q;
                end
            endcase
        end else begin
            ptr_d = ptr_q;
            cnt_d = cnt_q;
        end
    end

    // Stack pointer and occupancy registers with async clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Return-address entry array with async clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entry_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule : hpu_if_ras_ctrl
